// File: rtl/vec_pkg.sv
// Shared vector-layout helpers for the separation and packing stages.
// Derives words-per-vector, padding delta and padded-slice width, plus the
// FSM state encoding and a low-bit mask builder for the padded slice.
package vec_pkg;

  // Widest bus any mask must cover; callers slice the low BUS_WIDTH bits.
  localparam int MASK_MAX_W = 1024;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  function automatic int sub_vec_no(input int bus_w, input int vec_w);
    return (vec_w + bus_w - 1) / bus_w;
  endfunction

  function automatic int delta(input int bus_w, input int vec_w);
    return sub_vec_no(bus_w, vec_w) * bus_w - vec_w;
  endfunction

  function automatic int padded_slice_w(input int bus_w, input int vec_w);
    return bus_w - delta(bus_w, vec_w);
  endfunction

  // Ones in bits [w-1:0], zeros above.
  function automatic logic [MASK_MAX_W-1:0] slice_mask(input int w);
    logic [MASK_MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_MAX_W; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/vec_pack_acc.sv
// Shift-in accumulator: ORs each input word in above the current fill and
// emits the low BUS_WIDTH bits whenever at least a full word is held.
// Ports: shift_in/clear control, in_word/in_width data, emit/emit_word/next_fill
// describe the current shift-in combinationally, acc_low is the held residue.
module vec_pack_acc
  import vec_pkg::*;
#(
  parameter int BUS_WIDTH = 128,
  localparam int FW = $clog2(2 * BUS_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 shift_in,
  input  logic                 clear,
  input  logic [BUS_WIDTH-1:0] in_word,
  input  logic [FW-1:0]        in_width,
  output logic                 emit,
  output logic [BUS_WIDTH-1:0] emit_word,
  output logic [FW-1:0]        next_fill,
  output logic [BUS_WIDTH-1:0] acc_low
);

  logic [2*BUS_WIDTH-1:0] acc;
  logic [2*BUS_WIDTH-1:0] merged;
  logic [FW-1:0]          fill;
  logic [FW-1:0]          sum;
  logic                   full;

  // Bits of acc above fill are always zero, so a plain OR merges the word in.
  always_comb begin
    merged    = acc | ({{BUS_WIDTH{1'b0}}, in_word} << fill);
    sum       = fill + in_width;
    full      = (sum >= FW'(BUS_WIDTH));
    emit      = shift_in && full;
    emit_word = merged[BUS_WIDTH-1:0];
    next_fill = full ? (sum - FW'(BUS_WIDTH)) : sum;
  end

  assign acc_low = acc[BUS_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      acc  <= '0;
      fill <= '0;
    end else if (shift_in) begin
      acc  <= full ? (merged >> BUS_WIDTH) : merged;
      fill <= next_fill;
    end
  end

endmodule

// File: rtl/vec_pack.sv
// Re-packs zero-padded separated vectors into a gap-free BUS_WIDTH stream;
// a batch ends on up_Last and any residue is flushed as a padded dn_Last word.
// Ports: up_* separated input (valid/ready), dn_* packed output (valid/ready),
// err_Last sticky flag for up_Last arriving on a non-final sub-vector.
module vec_pack
  import vec_pkg::*;
#(
  parameter int BUS_WIDTH    = 128,
  parameter int VECTOR_WIDTH = 920
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [BUS_WIDTH-1:0] up_Vector,
  input  logic                 up_Valid,
  input  logic                 up_Last,
  output logic                 up_Ready,
  output logic [BUS_WIDTH-1:0] dn_Vector,
  output logic                 dn_Valid,
  output logic                 dn_Last,
  input  logic                 dn_Ready,
  output logic                 err_Last
);

  localparam int SUB_VEC_NO     = sub_vec_no(BUS_WIDTH, VECTOR_WIDTH);
  localparam int PADDED_SLICE_W = padded_slice_w(BUS_WIDTH, VECTOR_WIDTH);
  localparam int FW             = $clog2(2 * BUS_WIDTH);
  localparam int CW             = (SUB_VEC_NO > 1) ? $clog2(SUB_VEC_NO) : 1;

  localparam logic [MASK_MAX_W-1:0] MASK_FULL = slice_mask(PADDED_SLICE_W);
  localparam logic [BUS_WIDTH-1:0]  LAST_MASK = MASK_FULL[BUS_WIDTH-1:0];
  localparam logic [CW-1:0]         SUB_LAST  = CW'(SUB_VEC_NO - 1);

  state_t                 state;
  logic [CW-1:0]          r_SubCntr;
  logic                   accept;
  logic                   on_last_sub;
  logic                   flush_go;
  logic                   acc_clear;
  logic                   emit;
  logic [BUS_WIDTH-1:0]   masked;
  logic [BUS_WIDTH-1:0]   emit_word;
  logic [BUS_WIDTH-1:0]   acc_low;
  logic [FW-1:0]          in_width;
  logic [FW-1:0]          next_fill;

  assign up_Ready    = (state == RUN) && (!dn_Valid || dn_Ready);
  assign accept      = up_Valid && up_Ready;
  assign on_last_sub = (r_SubCntr == SUB_LAST);

  // Padding bits of the final sub-vector are not trusted to be zero.
  assign masked   = on_last_sub ? (up_Vector & LAST_MASK) : up_Vector;
  assign in_width = on_last_sub ? FW'(PADDED_SLICE_W) : FW'(BUS_WIDTH);

  // The flush word leaves only when the output register is free.
  assign flush_go  = (state == FLUSH) && (!dn_Valid || dn_Ready);
  assign acc_clear = flush_go || (accept && up_Last && (next_fill == '0));

  vec_pack_acc #(
    .BUS_WIDTH (BUS_WIDTH)
  ) u_acc (
    .clk       (clk),
    .rstn      (rstn),
    .shift_in  (accept),
    .clear     (acc_clear),
    .in_word   (masked),
    .in_width  (in_width),
    .emit      (emit),
    .emit_word (emit_word),
    .next_fill (next_fill),
    .acc_low   (acc_low)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= RUN;
      r_SubCntr <= '0;
      dn_Vector <= '0;
      dn_Valid  <= 1'b0;
      dn_Last   <= 1'b0;
      err_Last  <= 1'b0;
    end else begin
      if (accept) begin
        if (up_Last) begin
          r_SubCntr <= '0;
          if (!on_last_sub) err_Last <= 1'b1;
          if (next_fill != '0) state <= FLUSH;
        end else begin
          r_SubCntr <= on_last_sub ? '0 : r_SubCntr + 1'b1;
        end
      end

      // A word completed by the terminating accept is last only if nothing
      // remains behind it; otherwise the flush word carries dn_Last.
      if (emit) begin
        dn_Vector <= emit_word;
        dn_Valid  <= 1'b1;
        dn_Last   <= up_Last && (next_fill == '0);
      end else if (flush_go) begin
        dn_Vector <= acc_low;
        dn_Valid  <= 1'b1;
        dn_Last   <= 1'b1;
        state     <= RUN;
      end else if (dn_Ready) begin
        dn_Valid  <= 1'b0;
        dn_Last   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vec_pack.sv
module tb_vec_pack;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn = 1'b0;

  // Small configuration: 8-bit bus, 12-bit vectors.
  logic [7:0]   a_up_Vector;
  logic         a_up_Valid, a_up_Last, a_up_Ready;
  logic [7:0]   a_dn_Vector;
  logic         a_dn_Valid, a_dn_Last, a_dn_Ready, a_err_Last;

  // Default configuration: 128-bit bus, 920-bit vectors.
  logic [127:0] b_up_Vector;
  logic         b_up_Valid, b_up_Last, b_up_Ready;
  logic [127:0] b_dn_Vector;
  logic         b_dn_Valid, b_dn_Last, b_dn_Ready, b_err_Last;

  vec_pack #(.BUS_WIDTH(8), .VECTOR_WIDTH(12)) dut_a (
    .clk(clk), .rstn(rstn),
    .up_Vector(a_up_Vector), .up_Valid(a_up_Valid), .up_Last(a_up_Last), .up_Ready(a_up_Ready),
    .dn_Vector(a_dn_Vector), .dn_Valid(a_dn_Valid), .dn_Last(a_dn_Last), .dn_Ready(a_dn_Ready),
    .err_Last(a_err_Last)
  );

  vec_pack dut_b (
    .clk(clk), .rstn(rstn),
    .up_Vector(b_up_Vector), .up_Valid(b_up_Valid), .up_Last(b_up_Last), .up_Ready(b_up_Ready),
    .dn_Vector(b_dn_Vector), .dn_Valid(b_dn_Valid), .dn_Last(b_dn_Last), .dn_Ready(b_dn_Ready),
    .err_Last(b_err_Last)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: got no handshake, expected one within budget", name);
  endtask

  // Output monitors sample on the falling edge, between bench drive and DUT edge.
  logic [8:0] got_a[$];
  int         a_low_total = 0;
  logic       a_count_en  = 1'b0;
  always @(negedge clk) begin
    if (rstn && a_dn_Valid && a_dn_Ready) got_a.push_back({a_dn_Last, a_dn_Vector});
    if (a_count_en && !a_up_Ready) a_low_total++;
  end

  logic [128:0] got_b[$];
  int           b_stab_bad   = 0;
  logic         b_prev_stall = 1'b0;
  logic [127:0] b_prev_vec   = '0;
  logic         b_prev_last  = 1'b0;
  always @(negedge clk) begin
    if (b_prev_stall && (b_dn_Valid !== 1'b1 || b_dn_Vector !== b_prev_vec || b_dn_Last !== b_prev_last))
      b_stab_bad++;
    if (rstn && b_dn_Valid && b_dn_Ready) got_b.push_back({b_dn_Last, b_dn_Vector});
    b_prev_stall <= rstn && b_dn_Valid && !b_dn_Ready;
    b_prev_vec   <= b_dn_Vector;
    b_prev_last  <= b_dn_Last;
  end

  typedef struct {
    int         n_in;
    logic [7:0] din[4];
    int         n_out;
    logic [7:0] dout[3];
    int         exp_low;
    logic       exp_err;
  } case_t;

  function automatic case_t mk(input int n_in, input logic [31:0] din, input int n_out,
                               input logic [23:0] dout, input int low, input logic err);
    case_t c;
    c.n_in = n_in;
    for (int i = 0; i < 4; i++) c.din[i] = din[i*8 +: 8];
    c.n_out = n_out;
    for (int i = 0; i < 3; i++) c.dout[i] = dout[i*8 +: 8];
    c.exp_low = low;
    c.exp_err = err;
    return c;
  endfunction

  task automatic wait_acc_a(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (a_up_Ready) begin ok = 1'b1; break; end
    end
    if (!ok) timeout(name);
    @(posedge clk); #1;
  endtask

  task automatic wait_acc_b(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (b_up_Ready) begin ok = 1'b1; break; end
    end
    if (!ok) timeout(name);
    @(posedge clk); #1;
  endtask

  task automatic run_a(input case_t c, input int idx);
    int base, low0, budget;
    @(posedge clk); #1;
    base = got_a.size();
    low0 = a_low_total;
    a_count_en = 1'b1;
    for (int i = 0; i < c.n_in; i++) begin
      a_up_Vector = c.din[i];
      a_up_Valid  = 1'b1;
      a_up_Last   = (i == c.n_in - 1);
      wait_acc_a($sformatf("c%0d_in%0d", idx, i));
    end
    a_up_Valid = 1'b0;
    a_up_Last  = 1'b0;
    budget = 0;
    while (got_a.size() - base < c.n_out && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    repeat (3) @(negedge clk);
    a_count_en = 1'b0;
    chk($sformatf("c%0d_count", idx), got_a.size() - base, c.n_out);
    for (int i = 0; i < c.n_out; i++) begin
      if (base + i < got_a.size()) begin
        chk($sformatf("c%0d_w%0d_dat", idx, i), got_a[base+i][7:0], c.dout[i]);
        chk($sformatf("c%0d_w%0d_last", idx, i), got_a[base+i][8], (i == c.n_out - 1));
      end
    end
    chk($sformatf("c%0d_ready_low_cycles", idx), a_low_total - low0, c.exp_low);
    chk($sformatf("c%0d_err", idx), a_err_Last, c.exp_err);
  endtask

  case_t        cases[6];
  logic [919:0] vecs[4];
  logic [927:0] tmp;
  logic [127:0] exp_b[$];
  bit           sb[$];
  logic [127:0] w;
  logic [127:0] g;
  int           bbase;
  int           budget;
  logic         b_done;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1);
  end

  initial begin
    a_up_Vector = '0; a_up_Valid = 1'b0; a_up_Last = 1'b0; a_dn_Ready = 1'b1;
    b_up_Vector = '0; b_up_Valid = 1'b0; b_up_Last = 1'b0; b_dn_Ready = 1'b1;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("a_rst_dn_valid", a_dn_Valid, 0);
    chk("a_rst_dn_last", a_dn_Last, 0);
    chk("a_rst_dn_vector", a_dn_Vector, 0);
    chk("a_rst_err", a_err_Last, 0);
    chk("a_rst_up_ready", a_up_Ready, 1);
    chk("b_rst_dn_valid", b_dn_Valid, 0);
    chk("b_rst_dn_last", b_dn_Last, 0);
    chk("b_rst_dn_vector", b_dn_Vector, 0);
    chk("b_rst_err", b_err_Last, 0);
    chk("b_rst_up_ready", b_up_Ready, 1);

    // Stream words for the 8/12 config: word0 in the low byte. Expected
    // outputs are the packed stream itself, low byte first.
    cases[0] = mk(2, 32'h00000ABC, 2, 24'h000ABC, 1, 1'b0); // single vector, flush
    cases[1] = mk(4, 32'h01230ABC, 3, 24'h123ABC, 0, 1'b0); // two vectors, no flush
    cases[2] = mk(4, 32'hF123FABC, 3, 24'h123ABC, 0, 1'b0); // dirty padding masked
    cases[3] = mk(2, 32'h0000FABC, 2, 24'h000ABC, 1, 1'b0); // single, dirty padding
    cases[4] = mk(1, 32'h0000005C, 1, 24'h00005C, 0, 1'b1); // early up_Last
    cases[5] = mk(2, 32'h0000FABC, 2, 24'h000ABC, 1, 1'b1); // clean restart, err held
    for (int i = 0; i < 6; i++) run_a(cases[i], i);

    // Reset in the middle of a batch with a word stuck in the output register.
    @(posedge clk); #1;
    a_dn_Ready  = 1'b0;
    a_up_Vector = 8'hBC; a_up_Valid = 1'b1; a_up_Last = 1'b0;
    wait_acc_a("rst_pre_in");
    a_up_Valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_dn_valid", a_dn_Valid, 1);
    bbase = got_a.size();
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    a_dn_Ready = 1'b1;
    @(negedge clk);
    chk("rst_dn_valid", a_dn_Valid, 0);
    chk("rst_err", a_err_Last, 0);
    chk("rst_up_ready", a_up_Ready, 1);
    repeat (4) @(negedge clk);
    chk("rst_no_flush_word", got_a.size() - bbase, 0);
    run_a(cases[1], 6);

    // Default config: four random 920-bit vectors under random backpressure.
    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < 29; j++) tmp[j*32 +: 32] = $urandom();
      vecs[v] = tmp[919:0];
      for (int i = 0; i < 920; i++) sb.push_back(vecs[v][i]);
    end
    while (sb.size() > 0) begin
      w = '0;
      for (int i = 0; i < 128; i++) if (sb.size() > 0) w[i] = sb.pop_front();
      exp_b.push_back(w);
    end

    bbase  = got_b.size();
    b_done = 1'b0;
    @(posedge clk); #1;
    fork
      begin
        for (int v = 0; v < 4; v++) begin
          for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 3) == 0) begin
              b_up_Valid = 1'b0;
              @(posedge clk); #1;
            end
            if (k < 7) begin
              b_up_Vector = vecs[v][k*128 +: 128];
            end else begin
              g = {$urandom(), $urandom(), $urandom(), $urandom()};
              b_up_Vector = {g[103:0], vecs[v][919:896]};
            end
            b_up_Valid = 1'b1;
            b_up_Last  = (v == 3) && (k == 7);
            wait_acc_b($sformatf("b_v%0d_k%0d", v, k));
          end
        end
        b_up_Valid = 1'b0;
        b_up_Last  = 1'b0;
        budget = 0;
        while (got_b.size() - bbase < 29 && budget < 2000) begin
          @(negedge clk);
          budget++;
        end
        repeat (4) @(negedge clk);
        b_done = 1'b1;
      end
      begin
        while (!b_done) begin
          @(posedge clk); #1;
          b_dn_Ready = ($urandom_range(0, 2) != 0);
        end
        b_dn_Ready = 1'b1;
      end
    join

    chk("b_count", got_b.size() - bbase, 29);
    for (int i = 0; i < 29; i++) begin
      if (bbase + i < got_b.size()) begin
        chk($sformatf("b_w%0d_dat", i), got_b[bbase+i][127:0], exp_b[i]);
        chk($sformatf("b_w%0d_last", i), got_b[bbase+i][128], (i == 28));
      end
    end
    chk("b_stall_stable_violations", b_stab_bad, 0);
    chk("b_err", b_err_Last, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vec_pack.md
# vec_pack

Stream packer for the vector datapath: accepts separated, zero-padded vectors (one vector per SUB_VEC_NO bus words, last word carrying PADDED_SLICE_W meaningful bits) and re-packs them into a continuous, gap-free stream of BUS_WIDTH words. It is the inverse of the vector separation stage. It sits on the write-back/loopback side, where result or test vectors are streamed to memory or to a host FIFO in packed form. A batch ends on up_Last; the final partial word is zero-padded and flushed with dn_Last.

## Interface
- BUS_WIDTH, 128, bus word width.
- VECTOR_WIDTH, 920, bits per vector.
- SUB_VEC_NO, ceil(VECTOR_WIDTH/BUS_WIDTH), words per separated vector (derived; do not override).
- clk  in  1  clock.
- rstn  in  1  reset: synchronous, active-low.
- up_Vector  in  BUS_WIDTH  separated sub-vector word.
- up_Valid  in  1  up_Vector valid.
- up_Last  in  1  word is the last sub-vector of the batch.
- up_Ready  out  1  word accepted this cycle when up_Valid && up_Ready.
- dn_Vector  out  BUS_WIDTH  packed stream word.
- dn_Valid  out  1  dn_Vector valid.
- dn_Last  out  1  last packed word of the batch.
- dn_Ready  in  1  downstream accepts word.
- err_Last  out  1  sticky: up_Last seen on a non-final sub-vector.

## Operation
- Constants: DELTA = SUB_VEC_NO*BUS_WIDTH - VECTOR_WIDTH; PADDED_SLICE_W = BUS_WIDTH - DELTA. DELTA = 0 is legal.
- Bit order: sub-vector k carries vector bits [k*BUS_WIDTH +: BUS_WIDTH]. In the last sub-vector only bits [PADDED_SLICE_W-1:0] are meaningful; the upper bits are ignored (masked), not trusted to be zero. Vector n occupies stream bits [n*VECTOR_WIDTH +: VECTOR_WIDTH]; output word m is stream bits [m*BUS_WIDTH +: BUS_WIDTH].
- Sub-vector counter r_SubCntr, 0..SUB_VEC_NO-1. It increments per accepted word and wraps after SUB_VEC_NO-1. Input width w = PADDED_SLICE_W when r_SubCntr == SUB_VEC_NO-1, otherwise BUS_WIDTH.
- Accumulator: 2*BUS_WIDTH bits, with fill count r_Fill in 0..BUS_WIDTH-1.
  - On accept: acc |= masked word << r_Fill; r_Fill += w.
  - If the sum is >= BUS_WIDTH: load acc[BUS_WIDTH-1:0] into the output register, shift acc right by BUS_WIDTH, and r_Fill -= BUS_WIDTH.
  - At most one output word is produced per input word.
- States:
  - RUN: normal operation.
  - FLUSH: entered on accept of up_Last with a nonzero residual. Emits acc[BUS_WIDTH-1:0] (bits above the residual are zero) with dn_Last=1. It then clears acc, r_Fill and r_SubCntr and returns to RUN.
- up_Last with zero residual:
  - The word produced by that accept carries dn_Last=1.
  - acc, r_Fill and r_SubCntr are cleared and the state stays RUN.
- up_Last while r_SubCntr != SUB_VEC_NO-1:
  - Sets err_Last.
  - The batch still terminates as above, with r_SubCntr cleared.
- up_Ready = (state == RUN) && (!dn_Valid || dn_Ready).
- Output register: holds until dn_Ready. No word is dropped or duplicated under backpressure.

## Timing
- Reset values: dn_Valid 0, dn_Last 0, dn_Vector 0, err_Last 0. up_Ready is 1 after reset (RUN, output empty). acc, r_Fill and r_SubCntr are 0 and the state is RUN.
- Latency: the output word is registered and dn_Valid rises the cycle after the input accept that completes it.
- Throughput: 1 word/cycle sustained in RUN. Each flush costs one extra output slot with up_Ready low.
- Accept-to-FLUSH: the flush word is emitted from FLUSH once the output register is free. If the accept of up_Last also completed a word, that word goes out first (dn_Last=0) and the flush word follows.
- Simultaneous dn_Ready and a new accept: the output register reloads in the same cycle and dn_Valid stays high.
- dn_Valid, dn_Vector and dn_Last are stable while dn_Valid && !dn_Ready.
- Reset mid-batch: all state is discarded and no flush word is emitted.

## Structure
- Shared package vec_pkg: DELTA, PADDED_SLICE_W and SUB_VEC_NO computation functions; state encoding (RUN, FLUSH); a mask function for the padded slice. These are shared with the separation stage.
- One sub-module is natural: vec_pack_acc, the shift-in accumulator with fill count and word emit. The top level keeps the FSM, counters and handshake.

## Test plan
- Config for the first three scenarios: BUS_WIDTH=8, VECTOR_WIDTH=12, so SUB_VEC_NO=2, PADDED_SLICE_W=4.
- Single vector, up_Last on the final word: input 0xBC, 0x0A -> outputs 0xBC, then 0x0A with dn_Last=1; up_Ready low for exactly one cycle (FLUSH).
- Two vectors, up_Last on the final word: input 0xBC, 0x0A, 0x23, 0x01 -> outputs 0xBC, 0x3A, 0x12 with dn_Last on 0x12; no FLUSH cycle.
- Masking: same stream with the padded words 0xFA and 0xF1 -> identical output.
- Backpressure, default 128/920 config: random dn_Ready stalls over 4 vectors -> exactly ceil(4*920/128)=29 words, bit-exact against the reference model, dn_Last on word 29 only, outputs stable during stalls.
- Error and reset:
  - up_Last on the first sub-vector -> err_Last=1 and held; the next batch packs correctly from an empty accumulator.
  - rstn low mid-batch -> next cycle dn_Valid=0, err_Last=0, up_Ready=1, and the following batch is bit-exact.
